pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Match sequencer for the Pong datapath on the 720p HDMI pipeline. It runs in the pixel clock domain and advances on the video generator's new-frame strobe. It decides when the puck is recentred and when it is allowed to move, keeps both players' scores, and declares the winner. Its outputs drive the Pong datapath's puck-enable/recentre inputs and the score overlay.

## Interface
Parameters:
- POINTS_TO_WIN, 7: score that ends the match; range 1–15.
- SERVE_DELAY_FRAMES, 60: frames spent in SERVE before the puck is released; must be ≥1.
- SCORE_HOLD_FRAMES, 90: frames spent in POINT showing the updated score; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- i_clk_pxl  in  1  pixel clock.
- i_rst  in  1  synchronous active-high reset.
- i_nf  in  1  one-cycle new-frame strobe from the video signal generator.
- i_start  in  1  start button level, already synchronised; only its rising edge is used.
- i_miss_left  in  1  one-cycle pulse: puck passed the left edge.
- i_miss_right  in  1  one-cycle pulse: puck passed the right edge.
- o_state  out  3  current state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- o_game_run  out  1  puck motion enable; high only in PLAY.
- o_puck_reset  out  1  one-cycle pulse that recentres the puck.
- o_serve_dir  out  1  serve direction: 0 = toward left, 1 = toward right.
- o_score_l  out  4  left player score.
- o_score_r  out  4  right player score.
- o_winner_valid  out  1  high in GAMEOVER.
- o_winner  out  1  0 = left won, 1 = right won; meaningful only while o_winner_valid is high.

## Operation
- Start edge: start_edge = i_start & ~start_q, where start_q is i_start registered each cycle.
- Frame counter (frame_cnt):
  - Width is $clog2(max(SERVE_DELAY_FRAMES, SCORE_HOLD_FRAMES)+1).
  - Clears on every state entry and increments on each i_nf.
- IDLE:
  - start_edge leads to SERVE.
  - Both scores clear and o_serve_dir is set to 1.
- SERVE:
  - An i_nf arriving while frame_cnt == SERVE_DELAY_FRAMES-1 leads to PLAY.
- PLAY:
  - i_miss_left: o_score_r increments and o_serve_dir is set to 0; go to POINT.
  - i_miss_right: o_score_l increments and o_serve_dir is set to 1; go to POINT.
  - If both arrive in the same cycle, i_miss_left wins and i_miss_right is dropped.
  - Scores saturate at POINTS_TO_WIN.
- POINT:
  - An i_nf arriving while frame_cnt == SCORE_HOLD_FRAMES-1 ends the hold.
  - If either score == POINTS_TO_WIN, go to GAMEOVER and set o_winner = (o_score_r == POINTS_TO_WIN).
  - Otherwise go to SERVE.
- GAMEOVER:
  - Scores and the winner are held.
  - start_edge leads to SERVE with scores cleared and o_serve_dir set to 1, exactly as from IDLE.
- Ignored inputs:
  - i_miss_left and i_miss_right are ignored outside PLAY.
  - start_edge is ignored in SERVE, PLAY and POINT.
  - i_nf has no effect in IDLE and GAMEOVER.
- o_puck_reset pulses for exactly one cycle on every entry to SERVE.
- Encoding 5–7 is illegal; the next cycle goes to IDLE with all outputs at reset values.

## Timing
- All outputs are registered.
- An event sampled at edge N is visible on o_state, the scores and o_game_run after edge N.
- o_puck_reset is high in the first cycle o_state reads SERVE, and low after that.
- SERVE lasts exactly SERVE_DELAY_FRAMES i_nf strobes. The PLAY transition occurs on the edge sampling the last strobe.
- POINT lasts exactly SCORE_HOLD_FRAMES strobes, with the same edge rule.
- o_game_run:
  - Rises with the edge that enters PLAY.
  - Falls with the edge that samples the miss; the datapath sees no puck motion in the following frame.
- Reset values: o_state=0, o_game_run=0, o_puck_reset=0, o_serve_dir=1, o_score_l=0, o_score_r=0, o_winner_valid=0, o_winner=0, frame_cnt=0, start_q=0.
- Reset asserted mid-match forces IDLE on the next edge and takes priority over every input.
- i_nf coinciding with a state entry:
  - The entry clears frame_cnt; that strobe is not counted.
  - The same applies to an i_nf arriving while in PLAY or IDLE.
- start_edge and i_nf in the same cycle in IDLE: the start is taken, and the strobe is not counted.
- A held i_start produces no second start; the button must go low and then high again.

## Test plan
Bench parameters: POINTS_TO_WIN=3, SERVE_DELAY_FRAMES=2, SCORE_HOLD_FRAMES=3.

- Reset: hold i_rst 2 cycles, then release.
  - All outputs at their reset values; o_state=0.
  - i_nf pulses leave o_state=0.
- Start and serve: raise i_start.
  - Next cycle: o_state=1 and o_puck_reset=1 for one cycle.
  - After 2 i_nf strobes: o_state=2 and o_game_run=1.
  - Holding i_start high gives no further o_puck_reset.
- Point: in PLAY, pulse i_miss_right.
  - Next cycle: o_state=3, o_score_l=1, o_game_run=0, o_serve_dir=1.
  - After 3 strobes: o_state=1 with an o_puck_reset pulse.
- Simultaneous misses: pulse i_miss_left and i_miss_right in the same cycle.
  - o_score_r increments by 1 and o_score_l is unchanged.
  - Misses pulsed during SERVE or POINT leave the scores unchanged.
- Match end: right player scores 3 times.
  - After the third hold: o_state=4, o_winner_valid=1, o_winner=1, o_score_r=3 held.
  - Then raise i_start: o_state=1, both scores 0, o_winner_valid=0.
- Reset mid-match: assert i_rst during PLAY with o_score_l=2.
  - Next cycle: o_state=0, scores 0, o_game_run=0.

Source files
------------

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve/play/point/game-over flow, scoring and winner,
// stepped by the video generator's new-frame strobe in the pixel clock domain.
module pong_match_controller #(
  parameter int POINTS_TO_WIN      = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SCORE_HOLD_FRAMES  = 90
) (
  input  logic       i_clk_pxl,
  input  logic       i_rst,
  input  logic       i_nf,
  input  logic       i_start,
  input  logic       i_miss_left,
  input  logic       i_miss_right,
  output logic [2:0] o_state,
  output logic       o_game_run,
  output logic       o_puck_reset,
  output logic       o_serve_dir,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic       o_winner_valid,
  output logic       o_winner
);

  localparam int MAX_FRAMES = (SERVE_DELAY_FRAMES > SCORE_HOLD_FRAMES) ?
                              SERVE_DELAY_FRAMES : SCORE_HOLD_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(SCORE_HOLD_FRAMES - 1);
  localparam logic [3:0]    WIN_SCORE  = 4'(POINTS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          start_q, start_edge;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic          serve_dir_q, serve_dir_d;
  logic          winner_q, winner_d;
  logic          game_run_q, puck_reset_q, winner_valid_q;

  assign start_edge = i_start & ~start_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_SCORE) ? s : s + 4'd1;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      IDLE, GAMEOVER: begin
        if (start_edge) begin
          state_d     = SERVE;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = 1'b1;
        end
      end
      SERVE: begin
        if (i_nf) begin
          if (frame_cnt_q == SERVE_LAST) state_d = PLAY;
          else                           frame_cnt_d = frame_cnt_q + CW'(1);
        end
      end
      PLAY: begin
        // A left miss wins over a simultaneous right miss.
        if (i_miss_left) begin
          score_r_d   = sat_inc(score_r_q);
          serve_dir_d = 1'b0;
          state_d     = POINT;
        end else if (i_miss_right) begin
          score_l_d   = sat_inc(score_l_q);
          serve_dir_d = 1'b1;
          state_d     = POINT;
        end
      end
      POINT: begin
        if (i_nf) begin
          if (frame_cnt_q == HOLD_LAST) begin
            if (score_l_q == WIN_SCORE || score_r_q == WIN_SCORE) begin
              state_d  = GAMEOVER;
              winner_d = (score_r_q == WIN_SCORE);
            end else begin
              state_d = SERVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        score_l_d   = 4'd0;
        score_r_d   = 4'd0;
        serve_dir_d = 1'b1;
        winner_d    = 1'b0;
      end
    endcase

    // Entering any state restarts the frame count; a coincident strobe is lost.
    if (state_d != state_q) frame_cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk_pxl) begin
    if (i_rst) begin
      state_q        <= IDLE;
      frame_cnt_q    <= '0;
      start_q        <= 1'b0;
      score_l_q      <= 4'd0;
      score_r_q      <= 4'd0;
      serve_dir_q    <= 1'b1;
      winner_q       <= 1'b0;
      game_run_q     <= 1'b0;
      puck_reset_q   <= 1'b0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      start_q        <= i_start;
      score_l_q      <= score_l_d;
      score_r_q      <= score_r_d;
      serve_dir_q    <= serve_dir_d;
      winner_q       <= winner_d;
      game_run_q     <= (state_d == PLAY);
      puck_reset_q   <= (state_d == SERVE) && (state_q != SERVE);
      winner_valid_q <= (state_d == GAMEOVER);
    end
  end

  assign o_state        = state_q;
  assign o_game_run     = game_run_q;
  assign o_puck_reset   = puck_reset_q;
  assign o_serve_dir    = serve_dir_q;
  assign o_score_l      = score_l_q;
  assign o_score_r      = score_r_q;
  assign o_winner_valid = winner_valid_q;
  assign o_winner       = winner_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: each step queues the expected
// post-edge outputs, then pops and compares them after the clock edge.
module tb_pong_match_controller;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_nf = 1'b0, i_start = 1'b0;
  logic       i_miss_left = 1'b0, i_miss_right = 1'b0;
  logic [2:0] o_state;
  logic       o_game_run, o_puck_reset, o_serve_dir, o_winner_valid, o_winner;
  logic [3:0] o_score_l, o_score_r;

  int n_checks = 0;
  int n_errors = 0;

  pong_match_controller #(
    .POINTS_TO_WIN     (3),
    .SERVE_DELAY_FRAMES(2),
    .SCORE_HOLD_FRAMES (3)
  ) dut (
    .i_clk_pxl     (clk),
    .i_rst         (i_rst),
    .i_nf          (i_nf),
    .i_start       (i_start),
    .i_miss_left   (i_miss_left),
    .i_miss_right  (i_miss_right),
    .o_state       (o_state),
    .o_game_run    (o_game_run),
    .o_puck_reset  (o_puck_reset),
    .o_serve_dir   (o_serve_dir),
    .o_score_l     (o_score_l),
    .o_score_r     (o_score_r),
    .o_winner_valid(o_winner_valid),
    .o_winner      (o_winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       run, pr, dir, wv, w;
    logic [3:0] sl, sr;
    bit         chk_w;
  } exp_t;

  exp_t sb[$];

  // Expected post-edge values, edited by the directed sequence below.
  logic [2:0] e_st;
  logic       e_run, e_pr, e_dir, e_wv, e_w;
  logic [3:0] e_sl, e_sr;
  bit         e_chk_w;

  task automatic set_exp(input logic [2:0] st, input logic run, input logic pr,
                         input logic dir, input logic [3:0] sl,
                         input logic [3:0] sr, input logic wv);
    e_st = st; e_run = run; e_pr = pr; e_dir = dir;
    e_sl = sl; e_sr = sr; e_wv = wv;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".state"},     {1'b0, o_state},        {1'b0, e.st});
    chk({e.tag, ".game_run"},  {3'b0, o_game_run},     {3'b0, e.run});
    chk({e.tag, ".puck_reset"},{3'b0, o_puck_reset},   {3'b0, e.pr});
    chk({e.tag, ".serve_dir"}, {3'b0, o_serve_dir},    {3'b0, e.dir});
    chk({e.tag, ".score_l"},   o_score_l,              e.sl);
    chk({e.tag, ".score_r"},   o_score_r,              e.sr);
    chk({e.tag, ".win_valid"}, {3'b0, o_winner_valid}, {3'b0, e.wv});
    if (e.chk_w) chk({e.tag, ".winner"}, {3'b0, o_winner}, {3'b0, e.w});
  endtask

  // Drive one cycle of pulses, queue the expectation, clock, then compare.
  task automatic step(input string tag, input logic nf, input logic ml, input logic mr);
    exp_t e;
    i_nf = nf; i_miss_left = ml; i_miss_right = mr;
    e.tag = tag; e.st = e_st; e.run = e_run; e.pr = e_pr; e.dir = e_dir;
    e.sl = e_sl; e.sr = e_sr; e.wv = e_wv; e.w = e_w; e.chk_w = e_chk_w;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_nf = 1'b0; i_miss_left = 1'b0; i_miss_right = 1'b0;
    compare_front();
  endtask

  initial begin
    // Reset, including miss pulses that must be ignored.
    set_exp(3'd0, 0, 0, 1, 4'd0, 4'd0, 0); e_w = 1'b0; e_chk_w = 1'b1;
    step("reset_a", 0, 0, 0);
    step("reset_b", 1, 1, 1);
    i_rst = 1'b0;
    step("idle_nf_a", 1, 0, 0);
    step("idle_nf_b", 1, 0, 0);
    step("idle_miss", 0, 1, 1);

    // Start coinciding with a strobe: the strobe must not count.
    i_start = 1'b1;
    set_exp(3'd1, 0, 1, 1, 4'd0, 4'd0, 0); step("start_with_nf", 1, 0, 0);
    set_exp(3'd1, 0, 0, 1, 4'd0, 4'd0, 0); step("serve_pr_drop", 0, 0, 0);
    step("serve_miss", 0, 1, 1);
    step("serve_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 1, 4'd0, 4'd0, 0); step("serve_nf2_play", 1, 0, 0);
    step("play_nf", 1, 0, 0);
    i_start = 1'b0; step("play_start_low", 0, 0, 0);
    i_start = 1'b1; step("play_start_ignored", 0, 0, 0);

    // Right miss: left scores.
    set_exp(3'd3, 0, 0, 1, 4'd1, 4'd0, 0); step("miss_right", 0, 0, 1);
    step("point_miss", 0, 1, 1);
    step("point_nf1", 1, 0, 0);
    step("point_nf2", 1, 0, 0);
    set_exp(3'd1, 0, 1, 1, 4'd1, 4'd0, 0); step("point_nf3_serve", 1, 0, 0);
    set_exp(3'd1, 0, 0, 1, 4'd1, 4'd0, 0); step("serve2_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 1, 4'd1, 4'd0, 0); step("serve2_nf2_play", 1, 0, 0);

    // Simultaneous misses: left miss wins, right scores once.
    set_exp(3'd3, 0, 0, 0, 4'd1, 4'd1, 0); step("miss_both", 0, 1, 1);
    step("hold2_nf1", 1, 0, 0);
    step("hold2_nf2", 1, 0, 0);
    set_exp(3'd1, 0, 1, 0, 4'd1, 4'd1, 0); step("hold2_nf3_serve", 1, 0, 0);
    set_exp(3'd1, 0, 0, 0, 4'd1, 4'd1, 0); step("serve3_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 0, 4'd1, 4'd1, 0); step("serve3_nf2_play", 1, 0, 0);
    set_exp(3'd3, 0, 0, 0, 4'd1, 4'd2, 0); step("miss_left_2", 0, 1, 0);
    step("hold3_nf1", 1, 0, 0);
    step("hold3_nf2", 1, 0, 0);
    set_exp(3'd1, 0, 1, 0, 4'd1, 4'd2, 0); step("hold3_nf3_serve", 1, 0, 0);
    set_exp(3'd1, 0, 0, 0, 4'd1, 4'd2, 0); step("serve4_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 0, 4'd1, 4'd2, 0); step("serve4_nf2_play", 1, 0, 0);
    set_exp(3'd3, 0, 0, 0, 4'd1, 4'd3, 0); step("miss_left_3", 0, 1, 0);
    step("hold4_nf1", 1, 0, 0);
    step("hold4_nf2", 1, 0, 0);

    // Match end: right wins and everything is held.
    set_exp(3'd4, 0, 0, 0, 4'd1, 4'd3, 1); e_w = 1'b1;
    step("gameover", 1, 0, 0);
    step("go_nf", 1, 0, 0);
    step("go_miss", 0, 1, 1);
    i_start = 1'b0; step("go_start_low", 0, 0, 0);

    // Restart from GAMEOVER.
    i_start = 1'b1;
    set_exp(3'd1, 0, 1, 1, 4'd0, 4'd0, 0); e_chk_w = 1'b0;
    step("restart", 0, 0, 0);
    set_exp(3'd1, 0, 0, 1, 4'd0, 4'd0, 0); step("rs_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 1, 4'd0, 4'd0, 0); step("rs_nf2_play", 1, 0, 0);
    set_exp(3'd3, 0, 0, 1, 4'd1, 4'd0, 0); step("rs_miss_right_1", 0, 0, 1);
    step("rs_hold_nf1", 1, 0, 0);
    step("rs_hold_nf2", 1, 0, 0);
    set_exp(3'd1, 0, 1, 1, 4'd1, 4'd0, 0); step("rs_hold_nf3", 1, 0, 0);
    set_exp(3'd1, 0, 0, 1, 4'd1, 4'd0, 0); step("rs2_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 1, 4'd1, 4'd0, 0); step("rs2_nf2_play", 1, 0, 0);
    set_exp(3'd3, 0, 0, 1, 4'd2, 4'd0, 0); step("rs_miss_right_2", 0, 0, 1);
    step("rs2_hold_nf1", 1, 0, 0);
    step("rs2_hold_nf2", 1, 0, 0);
    set_exp(3'd1, 0, 1, 1, 4'd2, 4'd0, 0); step("rs2_hold_nf3", 1, 0, 0);
    set_exp(3'd1, 0, 0, 1, 4'd2, 4'd0, 0); step("rs3_nf1", 1, 0, 0);
    set_exp(3'd2, 1, 0, 1, 4'd2, 4'd0, 0); step("rs3_nf2_play", 1, 0, 0);

    // Reset mid-match overrides a coincident miss.
    i_rst = 1'b1;
    set_exp(3'd0, 0, 0, 1, 4'd0, 4'd0, 0); e_w = 1'b0; e_chk_w = 1'b1;
    step("reset_mid", 0, 0, 1);
    i_rst = 1'b0; i_start = 1'b0;
    step("after_reset", 1, 0, 0);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
